// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED mode sequencer: mode values, press FSM states,
// and a counter-width helper.
package led_seq_pkg;

  localparam logic [1:0] MODE_OFF  = 2'd0;
  localparam logic [1:0] MODE_ON   = 2'd1;
  localparam logic [1:0] MODE_SLOW = 2'd2;
  localparam logic [1:0] MODE_FAST = 2'd3;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PRESSED   = 2'd1;
  localparam logic [1:0] ST_LONG_HELD = 2'd2;

  // Bits needed to count 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stability-count debouncer.
module btn_debounce
  import led_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN,
  output logic BTN_DB
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] stab_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= BTN;
      sync2_q <= sync1_q;
    end
  end

  // Any cycle where the synced value matches the output restarts the count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stab_q <= '0;
      BTN_DB <= 1'b0;
    end else if (sync2_q == BTN_DB) begin
      stab_q <= '0;
    end else if (stab_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      stab_q <= '0;
      BTN_DB <= sync2_q;
    end else begin
      stab_q <= stab_q + CW'(1);
    end
  end

endmodule

// File: rtl/led_mode_sequencer.sv
// Button-driven LED mode sequencer: short press advances OFF/ON/SLOW/FAST,
// long press forces OFF; LED blinks at a per-mode half-period.
module led_mode_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 250000,
  parameter int unsigned LONG_PRESS_CYCLES = 24000000,
  parameter int unsigned SLOW_HALF         = 6000000,
  parameter int unsigned FAST_HALF         = 1500000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BTN,
  output logic       LED,
  output logic [1:0] MODE,
  output logic       PRESS_ACK
);

  localparam int unsigned HW       = cnt_width(LONG_PRESS_CYCLES + 1);
  localparam int unsigned MAX_HALF = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
  localparam int unsigned BW       = cnt_width(MAX_HALF);

  logic          btn_db;
  logic          btn_db_q;
  logic [1:0]    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    mode_q, mode_d;
  logic          mode_evt_c;
  logic [BW-1:0] blink_q;
  logic [BW-1:0] half_c;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .CLK   (CLK),
    .RST_N (RST_N),
    .BTN   (BTN),
    .BTN_DB(btn_db)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      mode_q    <= MODE_OFF;
      btn_db_q  <= 1'b0;
      PRESS_ACK <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      mode_q    <= mode_d;
      btn_db_q  <= btn_db;
      PRESS_ACK <= mode_evt_c;
    end
  end

  // Press FSM; hold counter saturates at LONG_PRESS_CYCLES once long-held.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    mode_d     = mode_q;
    mode_evt_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (btn_db && !btn_db_q) begin
          state_d = ST_PRESSED;
          hold_d  = '0;
        end
      end
      ST_PRESSED: begin
        if (!btn_db) begin
          state_d    = ST_IDLE;
          mode_d     = mode_q + 2'd1;
          mode_evt_c = 1'b1;
        end else if (hold_q >= HW'(LONG_PRESS_CYCLES - 1)) begin
          state_d    = ST_LONG_HELD;
          hold_d     = HW'(LONG_PRESS_CYCLES);
          mode_d     = MODE_OFF;
          mode_evt_c = 1'b1;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_LONG_HELD: begin
        if (!btn_db) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign half_c = (mode_q == MODE_SLOW) ? BW'(SLOW_HALF - 1) : BW'(FAST_HALF - 1);

  // A mode change restarts the blink phase so blinking modes open high.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      blink_q <= '0;
      LED     <= 1'b0;
    end else if (mode_evt_c) begin
      blink_q <= '0;
      LED     <= (mode_d != MODE_OFF);
    end else begin
      case (mode_q)
        MODE_OFF: begin
          blink_q <= '0;
          LED     <= 1'b0;
        end
        MODE_ON: begin
          blink_q <= '0;
          LED     <= 1'b1;
        end
        default: begin
          if (blink_q >= half_c) begin
            blink_q <= '0;
            LED     <= ~LED;
          end else begin
            blink_q <= blink_q + BW'(1);
          end
        end
      endcase
    end
  end

  assign MODE = mode_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed bench for led_mode_sequencer with small timing parameters.
module tb_led_mode_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       BTN;
  logic       LED;
  logic [1:0] MODE;
  logic       PRESS_ACK;

  int checks   = 0;
  int failures = 0;
  int ack_cnt  = 0;

  led_mode_sequencer #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(20),
    .SLOW_HALF        (8),
    .FAST_HALF        (2)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .BTN      (BTN),
    .LED      (LED),
    .MODE     (MODE),
    .PRESS_ACK(PRESS_ACK)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (PRESS_ACK === 1'b1) ack_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    BTN   = 1'b0;
    tick(3);
    RST_N = 1'b1;
    tick(2);
  endtask

  // Short press; leaves the bench on the first sample showing the new mode.
  task automatic short_press(input string tag, input int exp_mode, input int exp_led);
    logic [1:0] old;
    int n;
    old = MODE;
    BTN = 1'b1;
    tick(10);
    BTN = 1'b0;
    n = 0;
    while (MODE === old && n < 30) begin
      tick(1);
      n++;
    end
    chk({tag, "_mode"}, int'(MODE), exp_mode);
    chk({tag, "_led_first"}, int'(LED), exp_led);
  endtask

  task automatic measure(input logic lvl, output int n);
    n = 0;
    while (LED === lvl && n < 50) begin
      n++;
      tick(1);
    end
  endtask

  initial begin
    int base, hi, lo, n;

    // Reset values
    RST_N = 1'b0;
    BTN   = 1'b0;
    tick(3);
    chk("rst_mode", int'(MODE), 0);
    chk("rst_led", int'(LED), 0);
    chk("rst_ack", int'(PRESS_ACK), 0);
    RST_N = 1'b1;
    tick(2);

    // Single short press OFF -> ON
    base = ack_cnt;
    BTN = 1'b1;
    tick(10);
    BTN = 1'b0;
    tick(15);
    chk("short_mode", int'(MODE), 1);
    chk("short_led", int'(LED), 1);
    chk("short_ack", ack_cnt - base, 1);

    // Bouncing input never debounces
    base = ack_cnt;
    for (int i = 0; i < 15; i++) begin
      BTN = ~BTN;
      tick(2);
    end
    BTN = 1'b0;
    tick(12);
    chk("bounce_mode", int'(MODE), 1);
    chk("bounce_ack", ack_cnt - base, 0);

    // Four presses from reset with blink periods
    do_reset();
    base = ack_cnt;
    short_press("p1", 1, 1);
    tick(8);
    short_press("p2", 2, 1);
    measure(1'b1, hi);
    measure(1'b0, lo);
    chk("slow_high", hi, 8);
    chk("slow_low", lo, 8);
    short_press("p3", 3, 1);
    measure(1'b1, hi);
    measure(1'b0, lo);
    chk("fast_high", hi, 2);
    chk("fast_low", lo, 2);
    short_press("p4", 0, 0);
    tick(5);
    chk("p4_led_off", int'(LED), 0);
    chk("four_ack", ack_cnt - base, 4);

    // Long press from SLOW forces OFF
    short_press("to_on", 1, 1);
    tick(8);
    short_press("to_slow", 2, 1);
    tick(8);
    base = ack_cnt;
    BTN = 1'b1;
    n = 0;
    while (MODE !== 2'd0 && n < 40) begin
      tick(1);
      n++;
    end
    chk("long_window", int'(n >= 25 && n <= 29), 1);
    chk("long_led", int'(LED), 0);
    tick(40 - n);
    chk("long_held_mode", int'(MODE), 0);
    BTN = 1'b0;
    tick(15);
    chk("long_release_mode", int'(MODE), 0);
    chk("long_release_led", int'(LED), 0);
    chk("long_ack", ack_cnt - base, 1);

    // Long press while already OFF still acknowledges
    base = ack_cnt;
    BTN = 1'b1;
    tick(35);
    BTN = 1'b0;
    tick(15);
    chk("off_long_mode", int'(MODE), 0);
    chk("off_long_ack", ack_cnt - base, 1);

    // Reset mid-press abandons the press
    do_reset();
    short_press("pre_rst", 1, 1);
    tick(8);
    BTN = 1'b1;
    tick(12);
    RST_N = 1'b0;
    tick(1);
    base = ack_cnt;
    RST_N = 1'b1;
    BTN   = 1'b0;
    tick(20);
    chk("midrst_mode", int'(MODE), 0);
    chk("midrst_led", int'(LED), 0);
    chk("midrst_ack", ack_cnt - base, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
